// File: rtl/jpeg_fdct.sv
// jpeg_fdct: forward 8x8 2D DCT for the baseline JPEG encoder path.
// One block is held at a time. A row pass then a column pass share one
// multiply-accumulate unit (one product per cycle). Coefficients leave in
// raster order v*8+u.
//
// Optional feature macro: JPEG_FDCT_LEVEL_SHIFT_EN
//   defined   : inport_data_i is unsigned 0..255, the stored sample is data-128
//   undefined : inport_data_i is two's complement -128..127, sign-extended
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   img_start_i      synchronous abort/flush back to LOAD
//   inport_valid_i   input sample valid
//   inport_data_i    8-bit pixel sample
//   inport_idx_i     raster position y*8+x of the sample
//   inport_id_i      block tag, captured when idx 0 is accepted
//   inport_accept_o  high while the block buffer is loading
//   outport_valid_o  coefficient valid (held until accepted)
//   outport_data_o   signed coefficient F[v][u]
//   outport_idx_o    v*8+u
//   outport_id_o     tag of the current block
//   outport_accept_i downstream accepts the coefficient
module jpeg_fdct (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        img_start_i,
  input  logic        inport_valid_i,
  input  logic [7:0]  inport_data_i,
  input  logic [5:0]  inport_idx_i,
  input  logic [31:0] inport_id_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [15:0] outport_data_o,
  output logic [5:0]  outport_idx_o,
  output logic [31:0] outport_id_o,
  input  logic        outport_accept_i
);

  typedef enum logic [1:0] {
    LOAD,
    ROW,
    COL
  } state_t;

  state_t state, next_state;

  // cnt[8:6]: outer index (y in ROW, v in COL)
  // cnt[5:3]: u
  // cnt[2:0]: MAC tap (x in ROW, y in COL)
  logic [8:0]         cnt;
  logic signed [31:0] acc;
  logic signed [31:0] acc_sum;
  logic signed [15:0] rnd;
  logic signed [12:0] coef;
  logic signed [15:0] operand;
  logic signed [28:0] product;
  logic signed [8:0]  sample;

  logic signed [8:0]  s_buf [64];
  logic signed [15:0] t_buf [64];

  logic               in_fire;
  logic               out_fire;
  logic               out_valid;
  logic [15:0]        out_data;
  logic [5:0]         out_idx;
  logic [31:0]        out_id;

  // Cosine table C[k][n] = round(2048*c(k)*cos((2n+1)k*pi/16)).
  // (2n+1)k mod 32 is folded onto 0..8 quarter-wave magnitudes plus a sign.
  function automatic logic signed [12:0] cos_rom(input logic [2:0] k, input logic [2:0] n);
    logic [4:0]         m;
    logic [4:0]         r;
    logic               neg;
    logic signed [12:0] mag;
    m   = 5'(5'({n, 1'b1}) * 5'(k));
    r   = (m > 5'd16) ? 5'd0 - m : m;
    neg = (r > 5'd8);
    if (neg) r = 5'd16 - r;
    unique case (r[3:0])
      4'd0:    mag = 13'sd2048;
      4'd1:    mag = 13'sd2009;
      4'd2:    mag = 13'sd1892;
      4'd3:    mag = 13'sd1703;
      4'd4:    mag = 13'sd1448;
      4'd5:    mag = 13'sd1138;
      4'd6:    mag = 13'sd784;
      4'd7:    mag = 13'sd400;
      default: mag = 13'sd0;
    endcase
    if (k == 3'd0) return 13'sd1448;
    return neg ? -mag : mag;
  endfunction

`ifdef JPEG_FDCT_LEVEL_SHIFT_EN
  always_comb sample = 9'({1'b0, inport_data_i} - 9'd128);
`else
  always_comb sample = {inport_data_i[7], inport_data_i};
`endif

  assign in_fire         = inport_valid_i && (state == LOAD);
  assign out_fire        = out_valid && outport_accept_i;
  assign inport_accept_o = (state == LOAD);
  assign outport_valid_o = out_valid;
  assign outport_data_o  = out_data;
  assign outport_idx_o   = out_idx;
  assign outport_id_o    = out_id;

  // MAC operand selection: ROW multiplies C[u][x]*S[y][x],
  // COL multiplies C[v][y]*T[y][u].
  always_comb begin
    coef    = '0;
    operand = '0;
    if (state == ROW) begin
      coef    = cos_rom(cnt[5:3], cnt[2:0]);
      operand = 16'(s_buf[{cnt[8:6], cnt[2:0]}]);
    end else begin
      coef    = cos_rom(cnt[8:6], cnt[2:0]);
      operand = t_buf[{cnt[2:0], cnt[5:3]}];
    end
    product = 29'(coef) * 29'(operand);
    acc_sum = acc + 32'(product);
    rnd     = 16'((acc_sum + 32'sd2048) >>> 12);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= LOAD;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      LOAD:    if (in_fire && inport_idx_i == 6'd63) next_state = ROW;
      ROW:     if (cnt == 9'd511) next_state = COL;
      COL:     if (out_fire && cnt[8:3] == 6'd63) next_state = LOAD;
      default: next_state = LOAD;
    endcase
    if (img_start_i) next_state = LOAD;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_id    <= '0;
    end else if (img_start_i) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_fire && inport_idx_i == 6'd0) out_id <= inport_id_i;
        end
        ROW: begin
          cnt <= cnt + 9'd1;
          acc <= (cnt[2:0] == 3'd7) ? '0 : acc_sum;
        end
        COL: begin
          // The tap counter wraps on its own; the (v,u) position advances
          // only on downstream acceptance so idx stays tied to held data.
          if (out_valid) begin
            if (outport_accept_i) begin
              out_valid <= 1'b0;
              cnt[8:3]  <= cnt[8:3] + 6'd1;
            end
          end else begin
            cnt[2:0] <= cnt[2:0] + 3'd1;
            if (cnt[2:0] == 3'd7) begin
              acc       <= '0;
              out_data  <= rnd;
              out_idx   <= cnt[8:3];
              out_valid <= 1'b1;
            end else begin
              acc <= acc_sum;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffers hold their contents across reset and flush.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !img_start_i) begin
      if (in_fire) s_buf[inport_idx_i] <= sample;
      if (state == ROW && cnt[2:0] == 3'd7) t_buf[{cnt[8:6], cnt[5:3]}] <= rnd;
    end
  end

endmodule

// File: doc/jpeg_fdct.md
# jpeg_fdct

Forward 2D 8x8 DCT for the baseline JPEG encoder path, the counterpart of the decoder's inverse DCT. It accepts one 64-sample pixel block, performs a row pass then a column pass with a single time-shared multiply-accumulate unit, and emits 64 signed coefficients in raster (v*8+u) order toward the quantiser/zig-zag stage. It holds one block at a time: a new block is accepted only after the previous block's 64th coefficient has been accepted downstream.

## Interface
- No parameters.
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- img_start_i  in  1  synchronous abort/flush at image start.
- inport_valid_i  in  1  input sample valid.
- inport_data_i  in  8  pixel sample; format depends on configuration.
- inport_idx_i  in  6  raster position y*8+x of the sample.
- inport_id_i  in  32  block tag, captured when idx 0 is accepted.
- inport_accept_o  out  1  high when in LOAD.
- outport_valid_o  out  1  coefficient valid.
- outport_data_o  out  16  signed coefficient F[v][u].
- outport_idx_o  out  6  v*8+u.
- outport_id_o  out  32  tag of the current block.
- outport_accept_i  in  1  downstream accepts the coefficient.

## Operation
- Storage: sample buffer S (64 x 9b signed), transpose buffer T (64 x 16b signed), cosine ROM C[k][n] (64 x 13b signed), C[k][n] = round-half-away(4096 * c(k)/2 * cos((2n+1)k*pi/16)), with c(0) = 1/sqrt(2) and c(k>0) = 1. For example C[0][n] = 1448.
- States: LOAD, ROW, COL.
- LOAD:
  - Each accepted sample is written to S[idx].
  - Any order is allowed; S is not cleared between blocks, so unwritten entries keep stale data.
  - Accepting idx 63 moves the block to ROW.
- ROW: for y = 0..7 (outer) and u = 0..7, accumulate sum over x of C[u][x]*S[y][x], one product per cycle, x ascending. Write T[y][u] = (acc + 2048) >>> 12, truncated to 16b.
- COL: for v = 0..7 (outer) and u = 0..7, accumulate sum over y of C[v][y]*T[y][u]. The result (acc + 2048) >>> 12 is registered to outport_data_o, with outport_idx_o = v*8+u.
  - outport_valid_o is held with data stable until outport_accept_i.
  - The next coefficient's MAC starts the cycle after acceptance.
  - Accepting idx 63 returns the block to LOAD.
- Widths: product 22b; accumulator at least 26b signed; >>> is an arithmetic shift (floor).
- img_start_i: the next state is LOAD, outport_valid_o drops, and counters and the accumulator clear. It overrides any concurrent input or output handshake. Buffer contents are kept.
- Reset (asynchronous): state LOAD, counters 0, accumulator 0.
  - Output reset values: inport_accept_o=1, outport_valid_o=0, outport_data_o=0, outport_idx_o=0, outport_id_o=0.
  - A reset mid-block discards that block.

## Timing
- Accept of idx 63 at cycle N:
  - ROW occupies N+1..N+512.
  - The first COL MAC runs N+513..N+520.
  - outport_valid_o rises at N+521 with idx 0.
- Accept of coefficient k at cycle M: the next coefficient is valid at M+9 (8 MAC cycles + 1 register cycle).
- inport_accept_o is combinational from state; it goes low the cycle after idx 63 is accepted.
- The handshake completes when valid and accept are both high on a clock edge.
- The LOAD re-entry cycle follows acceptance of output idx 63, so input accept is back high on the next cycle.
- Block cycle with zero downstream stall: 64 load cycles + 512 + 64*9.

## Configuration
- JPEG_FDCT_LEVEL_SHIFT_EN defined: inport_data_i is unsigned 0..255, and S = data - 128.
- JPEG_FDCT_LEVEL_SHIFT_EN undefined: inport_data_i is already-shifted two's complement -128..127, sign-extended into S.

## Test plan
- Level shift on, block of all 255 -> F[0]=1015 (DC), all 63 AC = 0, idx 0..63 in order. Sample values are the block's input pixels, so all-255 input gives S=127.
- Level shift on, block of all 0 -> F[0]=-1024, AC all 0. Level shift off, all 0x00 -> all 64 outputs 0.
- Idx 63 accepted at cycle N, outport_accept_i tied high -> valid rises at N+521, next coefficients at +9 cycles. inport_accept_o is low from N+1 until after output 63 is accepted.
- Downstream holds accept low for 20 cycles on coefficient 5 -> data/idx/id stable throughout, coefficient 6 valid 9 cycles after release.
- Two blocks tagged 0x11 and 0x22 -> outport_id_o is 0x11 for all 64 of the first block and 0x22 for the second. Samples fed in reverse idx order give results identical to raster order.
- img_start_i pulsed during ROW and during COL output -> valid drops next cycle, accept high. A following all-255 block still yields DC 1015. rst_ni asserted mid-COL -> all outputs at reset values immediately.
